// File: rtl/bsg_dff_pipe_vr_pkg.sv
// Shared types and helpers for the elastic valid/ready register pipeline.
// Optional occupancy counter is enabled with BSG_DFF_PIPE_VR_COUNT_EN.
package bsg_dff_pipe_vr_pkg;

  localparam int default_width_p = 4;

  // Contents of one stage at the default width: valid flag plus payload.
  typedef struct packed {
    logic                       v;
    logic [default_width_p-1:0] data;
  } stage_s;

  function automatic int bsg_dff_pipe_vr_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bsg_dff_pipe_vr_if.sv
// One valid/ready handshake link. On the consumer side of the pipe "ready" is the yumi strobe.
interface bsg_dff_pipe_vr_if #(
  parameter int width_p = 4
);
  logic [width_p-1:0] data;
  logic               v;
  logic               ready;

  modport master (output data, output v, input ready);
  modport slave  (input data, input v, output ready);
endinterface

// File: rtl/bsg_dff_pipe_vr_stage.sv
// One pipeline stage: valid flop, clock-enabled data flop and the local move/load decision.
module bsg_dff_pipe_vr_stage #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_v,
  input  logic [width_p-1:0] in_data,
  input  logic               down_valid,
  input  logic               down_move,
  output logic               valid,
  output logic [width_p-1:0] data,
  output logic               move
);

  logic               valid_reg;
  logic [width_p-1:0] data_reg;
  logic               load;

  // The word leaves when the next slot is empty or is itself emptying this cycle.
  assign move = valid_reg & (~down_valid | down_move);
  assign load = ~valid_reg | move;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= in_v;
    end
  end

  // Payload is deliberately not reset; it only changes on a valid load.
  always_ff @(posedge clk_i) begin
    if (load & in_v) begin
      data_reg <= in_data;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/bsg_dff_pipe_vr.sv
// Elastic depth_p-stage register pipeline with collapsing bubbles and valid/ready on both sides.
// Define BSG_DFF_PIPE_VR_COUNT_EN to add the registered occupancy output count_o.
module bsg_dff_pipe_vr
  import bsg_dff_pipe_vr_pkg::*;
#(
  parameter int width_p = 4,
  parameter int depth_p = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bsg_dff_pipe_vr_if.slave        in_if,
  bsg_dff_pipe_vr_if.master       out_if
`ifdef BSG_DFF_PIPE_VR_COUNT_EN
  ,
  output logic [bsg_dff_pipe_vr_cnt_width(depth_p)-1:0] count_o
`endif
);

  if (depth_p < 1) begin : gen_bad_depth
    $error("bsg_dff_pipe_vr: depth_p must be at least 1");
  end

  logic [depth_p-1:0] valid_vec;
  logic [width_p-1:0] data_arr [depth_p];

  for (genvar gi = 0; gi < depth_p; gi++) begin : gen_stage
    logic               in_v_k;
    logic [width_p-1:0] in_data_k;
    logic               down_valid_k;
    logic               down_move_k;
    logic               move_k;

    if (gi == 0) begin : gen_head
      assign in_v_k    = in_if.v;
      assign in_data_k = in_if.data;
    end else begin : gen_body
      assign in_v_k    = valid_vec[gi-1];
      assign in_data_k = data_arr[gi-1];
    end

    // The last stage sees a permanently occupied successor that drains only on yumi.
    if (gi == depth_p - 1) begin : gen_tail
      assign down_valid_k = 1'b1;
      assign down_move_k  = out_if.ready;
    end else begin : gen_link
      assign down_valid_k = valid_vec[gi+1];
      assign down_move_k  = gen_stage[gi+1].move_k;
    end

    bsg_dff_pipe_vr_stage #(
      .width_p (width_p)
    ) stage (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .in_v       (in_v_k),
      .in_data    (in_data_k),
      .down_valid (down_valid_k),
      .down_move  (down_move_k),
      .valid      (valid_vec[gi]),
      .data       (data_arr[gi]),
      .move       (move_k)
    );
  end

  assign in_if.ready = ~reset_i & (~valid_vec[0] | gen_stage[0].move_k);
  assign out_if.v    = valid_vec[depth_p-1];
  assign out_if.data = data_arr[depth_p-1];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(out_if.ready && !out_if.v));
    end
  end

`ifdef BSG_DFF_PIPE_VR_COUNT_EN
  localparam int cnt_width_lp = bsg_dff_pipe_vr_cnt_width(depth_p);

  logic [cnt_width_lp-1:0] cnt_reg;
  logic                    accept;
  logic                    deq;

  assign accept = in_if.v & in_if.ready;
  assign deq    = out_if.ready & out_if.v;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_reg <= '0;
    end else if (accept & ~deq) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else if (deq & ~accept) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (cnt_reg == cnt_width_lp'($countones(valid_vec)));
    end
  end

  assign count_o = cnt_reg;
`endif

endmodule

// File: tb/tb_bsg_dff_pipe_vr.sv
// Self-checking bench: depth-3 and depth-1 pipes against a queue model of accept/emit timing.
module tb_bsg_dff_pipe_vr;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bsg_dff_pipe_vr_if #(.width_p(4)) in3 ();
  bsg_dff_pipe_vr_if #(.width_p(4)) out3 ();
  bsg_dff_pipe_vr_if #(.width_p(4)) in1 ();
  bsg_dff_pipe_vr_if #(.width_p(4)) out1 ();

`ifdef BSG_DFF_PIPE_VR_COUNT_EN
  logic [1:0] cnt3;
  logic [0:0] cnt1;
`endif

  bsg_dff_pipe_vr #(.width_p(4), .depth_p(3)) dut3 (
    .clk_i   (clk),
    .reset_i (reset),
    .in_if   (in3),
    .out_if  (out3)
`ifdef BSG_DFF_PIPE_VR_COUNT_EN
    ,
    .count_o (cnt3)
`endif
  );

  bsg_dff_pipe_vr #(.width_p(4), .depth_p(1)) dut1 (
    .clk_i   (clk),
    .reset_i (reset),
    .in_if   (in1),
    .out_if  (out1)
`ifdef BSG_DFF_PIPE_VR_COUNT_EN
    ,
    .count_o (cnt1)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit model_ok = 1'b0;

  // Model: a word accepted in cycle t is visible from t+depth, but never before the cycle
  // after its predecessor was taken.
  typedef struct {
    logic [3:0] data;
    int         vis;
  } word_t;

  word_t q3[$];
  word_t q1[$];

  logic       s_ready3, s_v3, s_ready1, s_v1;
  logic [3:0] s_data3, s_data1;
  int         s_cnt3, s_cnt1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input logic rst,
                      input logic v3i, input logic [3:0] d3i, input logic y3req,
                      input logic v1i, input logic [3:0] d1i, input logic y1req);
    logic ev3, ev1, y3, y1, er3, er1;
    logic [3:0] ed3, ed1;
    ev3 = (q3.size() > 0) && (q3[0].vis <= cyc);
    ev1 = (q1.size() > 0) && (q1[0].vis <= cyc);
    ed3 = ev3 ? q3[0].data : 4'h0;
    ed1 = ev1 ? q1[0].data : 4'h0;
    y3  = y3req & ev3;
    y1  = y1req & ev1;
    er3 = !rst && ((q3.size() < 3) || y3);
    er1 = !rst && ((q1.size() < 1) || y1);

    reset      = rst;
    in3.v      = v3i;
    in3.data   = d3i;
    out3.ready = y3;
    in1.v      = v1i;
    in1.data   = d1i;
    out1.ready = y1;

    @(negedge clk);
    s_ready3 = in3.ready;
    s_v3     = out3.v;
    s_data3  = out3.data;
    s_ready1 = in1.ready;
    s_v1     = out1.v;
    s_data1  = out1.data;
`ifdef BSG_DFF_PIPE_VR_COUNT_EN
    s_cnt3 = int'(cnt3);
    s_cnt1 = int'(cnt1);
`else
    s_cnt3 = q3.size();
    s_cnt1 = q1.size();
`endif
    if (model_ok) begin
      check("model ready d3", int'(s_ready3), int'(er3));
      check("model v_o d3", int'(s_v3), int'(ev3));
      if (ev3) check("model data_o d3", int'(s_data3), int'(ed3));
      check("model ready d1", int'(s_ready1), int'(er1));
      check("model v_o d1", int'(s_v1), int'(ev1));
      if (ev1) check("model data_o d1", int'(s_data1), int'(ed1));
`ifdef BSG_DFF_PIPE_VR_COUNT_EN
      check("model count d3", s_cnt3, q3.size());
      check("model count d1", s_cnt1, q1.size());
`endif
    end
    if (y3 && s_v3) $display("cycle %0d: depth3 dequeued %h", cyc, s_data3);
    if (y1 && s_v1) $display("cycle %0d: depth1 dequeued %h", cyc, s_data1);

    @(posedge clk);
    if (rst) begin
      q3.delete();
      q1.delete();
      model_ok = 1'b1;
    end else begin
      if (y3) begin
        void'(q3.pop_front());
        if (q3.size() > 0 && q3[0].vis < cyc + 1) q3[0].vis = cyc + 1;
      end
      if (v3i && er3) q3.push_back(word_t'{data: d3i, vis: cyc + 3});
      if (y1) begin
        void'(q1.pop_front());
        if (q1.size() > 0 && q1[0].vis < cyc + 1) q1[0].vis = cyc + 1;
      end
      if (v1i && er1) q1.push_back(word_t'{data: d1i, vis: cyc + 1});
    end
    cyc++;
    #1;
  endtask

  task automatic t3(input logic rst, input logic v, input logic [3:0] d, input logic y);
    tick(rst, v, d, y, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic t1(input logic v, input logic [3:0] d, input logic y);
    tick(1'b0, 1'b0, 4'h0, 1'b0, v, d, y);
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       y;
    logic       er;
    logic       ev;
    logic [3:0] ed;
    int         ec;
  } vec_t;

  vec_t tbl [19];
  int   got_data[$];
  int   got_cyc[$];

  initial begin
    // backpressure fill/drain followed by a bubble-collapse sequence (depth 3)
    tbl[0]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 0};
    tbl[1]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 4'h0, 1};
    tbl[2]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 2};
    tbl[3]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 3};
    tbl[4]  = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 4'h1, 3};
    tbl[5]  = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 4'h1, 3};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2, 3};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h2, 3};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h3, 2};
    tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h4, 1};
    tbl[10] = '{1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 4'h0, 0};
    tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1};
    tbl[12] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1};
    tbl[13] = '{1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 4'h7, 1};
    tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h7, 2};
    tbl[15] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h7, 2};
    tbl[16] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h7, 2};
    tbl[17] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h8, 1};
    tbl[18] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 0};

    reset = 1'b1;
    in3.v = 1'b0; in3.data = 4'h0; out3.ready = 1'b0;
    in1.v = 1'b0; in1.data = 4'h0; out1.ready = 1'b0;
    @(posedge clk);
    #1;

    // reset held two cycles with valid input present
    tick(1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 4'hA, 1'b0);
    check("reset ready d3 c0", int'(s_ready3), 0);
    check("reset ready d1 c0", int'(s_ready1), 0);
    tick(1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 4'hA, 1'b0);
    check("reset ready d3 c1", int'(s_ready3), 0);
    check("reset v_o d3 c1", int'(s_v3), 0);
    check("reset v_o d1 c1", int'(s_v1), 0);
    tick(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    check("post-reset ready d3", int'(s_ready3), 1);
    check("post-reset ready d1", int'(s_ready1), 1);
    check("post-reset v_o d3", int'(s_v3), 0);
    check("post-reset count d3", s_cnt3, 0);

    // single-word latency on an empty pipe
    t3(1'b0, 1'b1, 4'hA, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      t3(1'b0, 1'b0, 4'h0, 1'b1);
      check("latency v_o", int'(s_v3), (i == 3) ? 1 : 0);
      if (i == 3) check("latency data_o", int'(s_data3), 'hA);
    end

    // streaming with yumi held: back-to-back output
    for (int k = 0; k < 12; k++) begin
      t3(1'b0, k < 6, 4'(k + 1), 1'b1);
      if (k < 6) check("stream ready", int'(s_ready3), 1);
      if (s_v3) begin
        got_data.push_back(int'(s_data3));
        got_cyc.push_back(k);
      end
    end
    check("stream word count", got_data.size(), 6);
    for (int i = 0; i < got_data.size(); i++) begin
      check("stream data order", got_data[i], i + 1);
      check("stream no gaps", got_cyc[i], i + 3);
    end

    // table-driven backpressure and bubble sequence
    for (int i = 0; i < 19; i++) begin
      t3(1'b0, tbl[i].v, tbl[i].d, tbl[i].y);
      check($sformatf("table[%0d] ready", i), int'(s_ready3), int'(tbl[i].er));
      check($sformatf("table[%0d] v_o", i), int'(s_v3), int'(tbl[i].ev));
      if (tbl[i].ev) check($sformatf("table[%0d] data_o", i), int'(s_data3), int'(tbl[i].ed));
`ifdef BSG_DFF_PIPE_VR_COUNT_EN
      check($sformatf("table[%0d] count", i), s_cnt3, tbl[i].ec);
`endif
    end

    // full pipe flushed by a one-cycle reset: nothing old may come out afterwards
    t3(1'b0, 1'b1, 4'h9, 1'b0);
    t3(1'b0, 1'b1, 4'hA, 1'b0);
    t3(1'b0, 1'b1, 4'hB, 1'b0);
    t3(1'b0, 1'b1, 4'hC, 1'b0);
    check("full ready", int'(s_ready3), 0);
    check("full head", int'(s_data3), 'h9);
    t3(1'b1, 1'b1, 4'hD, 1'b1);
    for (int i = 0; i < 6; i++) begin
      t3(1'b0, 1'b0, 4'h0, 1'b1);
      check("flush v_o", int'(s_v3), 0);
    end

    // depth 1: full throughput, then stall when full
    for (int k = 0; k < 7; k++) begin
      t1(k < 5, 4'(k + 1), 1'b1);
      if (k < 5) check("d1 stream ready", int'(s_ready1), 1);
      check("d1 stream v_o", int'(s_v1), (k >= 1 && k <= 5) ? 1 : 0);
      if (k >= 1 && k <= 5) check("d1 stream data", int'(s_data1), k);
    end
    t1(1'b1, 4'hE, 1'b0);
    t1(1'b1, 4'hF, 1'b0);
    check("d1 full ready", int'(s_ready1), 0);
    check("d1 full data", int'(s_data1), 'hE);
    t1(1'b1, 4'hF, 1'b1);
    check("d1 drain ready", int'(s_ready1), 1);
    t1(1'b0, 4'h0, 1'b0);
    check("d1 next data", int'(s_data1), 'hF);
    t1(1'b0, 4'h0, 1'b1);
    t1(1'b0, 4'h0, 1'b0);
    check("d1 empty v_o", int'(s_v1), 0);

    // randomized traffic with occasional resets on both pipes
    for (int k = 0; k < 800; k++) begin
      tick($urandom_range(0, 79) == 0,
           1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
